// File: rtl/spi_flash_arbiter_if.sv
// Pin bundle between the two SPI masters, the shared config flash and the arbiter.
// The arbiter sits on the slave modport; a master/board model uses the master modport.
interface spi_flash_arbiter_if;
    logic dsp_req;
    logic dsp_gnt;
    logic cpu_req;
    logic cpu_gnt;
    logic dsp_spi_clk;
    logic dsp_spi_mosi;
    logic dsp_spi_cs_INV;
    logic dsp_spi_miso;
    logic cpu_spi_clk;
    logic cpu_spi_mosi;
    logic cpu_spi_cs_INV;
    logic cpu_spi_miso;
    logic flash_clk;
    logic flash_mosi;
    logic flash_cs_INV;
    logic flash_miso;
    logic timeout_event;

    modport slave (
        input  dsp_req, cpu_req,
        input  dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV,
        input  cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV,
        input  flash_miso,
        output dsp_gnt, cpu_gnt, dsp_spi_miso, cpu_spi_miso,
        output flash_clk, flash_mosi, flash_cs_INV, timeout_event
    );

    modport master (
        output dsp_req, cpu_req,
        output dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV,
        output cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV,
        output flash_miso,
        input  dsp_gnt, cpu_gnt, dsp_spi_miso, cpu_spi_miso,
        input  flash_clk, flash_mosi, flash_cs_INV, timeout_event
    );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Arbitrates the board SPI config flash between the DSP and CPU masters with a req/gnt
// handshake, a deselect guard between owners and an optional hold timeout with lockout.
module spi_flash_arbiter #(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned HOLD_TIMEOUT = 50000,
    parameter logic        IDLE_CLK     = 1'b0
) (
    input logic                sysclk,
    input logic                reset_INV,
    spi_flash_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StOwnDsp, StOwnCpu, StGuard} state_e;

    localparam logic [15:0] HoldLast  = 16'(HOLD_TIMEOUT - 1);
    localparam logic [7:0]  GuardLast = 8'(GUARD_CYCLES - 1);
    localparam bit          TimeoutEn = (HOLD_TIMEOUT != 0);

    logic [1:0]  dsp_sync_q, cpu_sync_q;
    logic        sreq_dsp, sreq_cpu;
    logic        avail_dsp, avail_cpu, own_req;
    state_e      state_q;
    logic [15:0] hold_cnt_q;
    logic [7:0]  guard_cnt_q;
    logic        last_cpu_q;
    logic        lock_dsp_q, lock_cpu_q;
    logic        dsp_gnt_q, cpu_gnt_q, timeout_q;

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            dsp_sync_q <= 2'b00;
            cpu_sync_q <= 2'b00;
        end else begin
            dsp_sync_q <= {dsp_sync_q[0], bus.dsp_req};
            cpu_sync_q <= {cpu_sync_q[0], bus.cpu_req};
        end
    end

    assign sreq_dsp  = dsp_sync_q[1];
    assign sreq_cpu  = cpu_sync_q[1];
    assign avail_dsp = sreq_dsp & ~lock_dsp_q;
    assign avail_cpu = sreq_cpu & ~lock_cpu_q;
    assign own_req   = (state_q == StOwnCpu) ? sreq_cpu : sreq_dsp;

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state_q     <= StIdle;
            hold_cnt_q  <= 16'd0;
            guard_cnt_q <= 8'd0;
            last_cpu_q  <= 1'b1;
            lock_dsp_q  <= 1'b0;
            lock_cpu_q  <= 1'b0;
            dsp_gnt_q   <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (!sreq_dsp) lock_dsp_q <= 1'b0;
            if (!sreq_cpu) lock_cpu_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // On a tie the master that did not own the flash last wins.
                    if (avail_dsp && (!avail_cpu || last_cpu_q)) begin
                        state_q    <= StOwnDsp;
                        dsp_gnt_q  <= 1'b1;
                        hold_cnt_q <= 16'd0;
                    end else if (avail_cpu) begin
                        state_q    <= StOwnCpu;
                        cpu_gnt_q  <= 1'b1;
                        hold_cnt_q <= 16'd0;
                    end
                end
                StOwnDsp, StOwnCpu: begin
                    if (!own_req || (TimeoutEn && hold_cnt_q == HoldLast)) begin
                        state_q     <= StGuard;
                        guard_cnt_q <= 8'd0;
                        dsp_gnt_q   <= 1'b0;
                        cpu_gnt_q   <= 1'b0;
                        last_cpu_q  <= (state_q == StOwnCpu);
                        // A release in the timeout cycle wins: no pulse, no lockout.
                        if (own_req) begin
                            timeout_q <= 1'b1;
                            if (state_q == StOwnCpu) lock_cpu_q <= 1'b1;
                            else                     lock_dsp_q <= 1'b1;
                        end
                    end else if (hold_cnt_q != 16'hFFFF) begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                StGuard: begin
                    if (guard_cnt_q == GuardLast) state_q <= StIdle;
                    else                          guard_cnt_q <= guard_cnt_q + 8'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.dsp_gnt       = dsp_gnt_q;
    assign bus.cpu_gnt       = cpu_gnt_q;
    assign bus.timeout_event = timeout_q;

    // Pin mux decodes the registered state so an async reset deselects the flash at once.
    always_comb begin
        bus.flash_cs_INV = 1'b1;
        bus.flash_clk    = IDLE_CLK;
        bus.flash_mosi   = 1'b0;
        bus.dsp_spi_miso = 1'b0;
        bus.cpu_spi_miso = 1'b0;
        if (state_q == StOwnDsp) begin
            bus.flash_cs_INV = bus.dsp_spi_cs_INV;
            bus.flash_clk    = bus.dsp_spi_clk;
            bus.flash_mosi   = bus.dsp_spi_mosi;
            bus.dsp_spi_miso = bus.flash_miso;
        end else if (state_q == StOwnCpu) begin
            bus.flash_cs_INV = bus.cpu_spi_cs_INV;
            bus.flash_clk    = bus.cpu_spi_clk;
            bus.flash_mosi   = bus.cpu_spi_mosi;
            bus.cpu_spi_miso = bus.flash_miso;
        end
    end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle with a behavioural ownership model.
module tb_spi_flash_arbiter;
    localparam int GUARD   = 4;
    localparam int TIMEOUT = 10;

    logic sysclk = 1'b0;
    logic reset_INV;
    int   n_tests = 0;
    int   n_fail  = 0;

    spi_flash_arbiter_if bus ();

    spi_flash_arbiter #(
        .GUARD_CYCLES(GUARD),
        .HOLD_TIMEOUT(TIMEOUT),
        .IDLE_CLK    (1'b0)
    ) dut (
        .sysclk   (sysclk),
        .reset_INV(reset_INV),
        .bus      (bus)
    );

    always #5 sysclk = ~sysclk;

    // Ownership model: owner -1 none, 0 DSP, 1 CPU; bit 0 of vectors is DSP, bit 1 CPU.
    typedef struct {
        int       owner;
        int       last;
        int       held;
        int       guard;
        bit [1:0] s1;
        bit [1:0] sreq;
        bit [1:0] lock;
        bit       to;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.owner = -1;
        r.last  = 1;
        r.held  = 0;
        r.guard = 0;
        r.s1    = 2'b00;
        r.sreq  = 2'b00;
        r.lock  = 2'b00;
        r.to    = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(model_t c, bit [1:0] req);
        model_t   n;
        bit [1:0] want;
        n    = c;
        n.to = 1'b0;
        want = c.sreq & ~c.lock;
        if (c.owner >= 0) begin
            n.held = c.held + 1;
            if (!c.sreq[c.owner]) begin
                n.last  = c.owner;
                n.owner = -1;
                n.guard = GUARD;
            end else if (n.held == TIMEOUT) begin
                n.lock[c.owner] = 1'b1;
                n.to    = 1'b1;
                n.last  = c.owner;
                n.owner = -1;
                n.guard = GUARD;
            end
        end else if (c.guard > 0) begin
            n.guard = c.guard - 1;
        end else begin
            if (want == 2'b11)  n.owner = 1 - c.last;
            else if (want[0])   n.owner = 0;
            else if (want[1])   n.owner = 1;
            n.held = 0;
        end
        n.lock = n.lock & c.sreq;
        n.sreq = c.s1;
        n.s1   = req;
        return n;
    endfunction

    always @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) m <= model_reset();
        else            m <= model_next(m, {bus.cpu_req, bus.dsp_req});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic quiesce();
        bus.dsp_req = 1'b0;
        bus.cpu_req = 1'b0;
        bus.dsp_spi_cs_INV = 1'b1;
        bus.cpu_spi_cs_INV = 1'b1;
        bus.dsp_spi_clk = 1'b0;
        bus.cpu_spi_clk = 1'b0;
        bus.dsp_spi_mosi = 1'b0;
        bus.cpu_spi_mosi = 1'b0;
        bus.flash_miso = 1'b0;
        tick(12);
    endtask

    task automatic test_reset();
        reset_INV = 1'b0;
        bus.dsp_req = 1'b1;
        bus.cpu_req = 1'b1;
        bus.dsp_spi_clk = 1'b1;
        bus.dsp_spi_cs_INV = 1'b0;
        bus.dsp_spi_mosi = 1'b1;
        bus.flash_miso = 1'b1;
        tick(3);
        n_tests++;
        if ({bus.cpu_gnt, bus.dsp_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnts: got %b%b expected 00", bus.cpu_gnt, bus.dsp_gnt);
        end
        n_tests++;
        if (bus.flash_cs_INV !== 1'b1) begin
            n_fail++; $display("FAIL reset_cs: got %b expected 1", bus.flash_cs_INV);
        end
        n_tests++;
        if ({bus.flash_clk, bus.flash_mosi} !== 2'b00) begin
            n_fail++; $display("FAIL reset_clk_mosi: got %b%b expected 00", bus.flash_clk,
                               bus.flash_mosi);
        end
        n_tests++;
        if ({bus.dsp_spi_miso, bus.cpu_spi_miso} !== 2'b00) begin
            n_fail++; $display("FAIL reset_miso: got %b%b expected 00", bus.dsp_spi_miso,
                               bus.cpu_spi_miso);
        end
        reset_INV = 1'b1;
        tick(2);
        n_tests++;
        if (bus.dsp_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt_early: got %b expected 0", bus.dsp_gnt);
        end
        tick(1);
        n_tests++;
        if ({bus.cpu_gnt, bus.dsp_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_gnt: got %b%b expected 01", bus.cpu_gnt,
                               bus.dsp_gnt);
        end
        n_tests++;
        if ({bus.flash_cs_INV, bus.flash_clk, bus.flash_mosi, bus.dsp_spi_miso} !== 4'b0111) begin
            n_fail++; $display("FAIL reset_dsp_mux: got %b%b%b%b expected 0111", bus.flash_cs_INV,
                               bus.flash_clk, bus.flash_mosi, bus.dsp_spi_miso);
        end
    endtask

    task automatic test_single_owner();
        int n = 0;
        quiesce();
        bus.cpu_req = 1'b1;
        while (bus.cpu_gnt !== 1'b1 && n < 8) begin tick(1); n++; end
        n_tests++;
        if (n != 3) begin
            n_fail++; $display("FAIL cpu_gnt_latency: got %0d expected 3", n);
        end
        for (int i = 0; i < 6; i++) begin
            bus.cpu_spi_cs_INV = 1'($urandom);
            bus.cpu_spi_clk    = 1'($urandom);
            bus.cpu_spi_mosi   = 1'($urandom);
            bus.dsp_spi_cs_INV = 1'($urandom);
            bus.dsp_spi_clk    = 1'($urandom);
            bus.dsp_spi_mosi   = 1'($urandom);
            bus.flash_miso     = 1'($urandom);
            #1;
            n_tests++;
            if ({bus.flash_cs_INV, bus.flash_clk, bus.flash_mosi} !==
                {bus.cpu_spi_cs_INV, bus.cpu_spi_clk, bus.cpu_spi_mosi}) begin
                n_fail++; $display("FAIL cpu_mux: got %b%b%b expected %b%b%b", bus.flash_cs_INV,
                                   bus.flash_clk, bus.flash_mosi, bus.cpu_spi_cs_INV,
                                   bus.cpu_spi_clk, bus.cpu_spi_mosi);
            end
            n_tests++;
            if ({bus.cpu_spi_miso, bus.dsp_spi_miso} !== {bus.flash_miso, 1'b0}) begin
                n_fail++; $display("FAIL cpu_miso: got %b%b expected %b0", bus.cpu_spi_miso,
                                   bus.dsp_spi_miso, bus.flash_miso);
            end
            tick(1);
        end
    endtask

    task automatic test_handover();
        int n = 0;
        quiesce();
        bus.dsp_req = 1'b1;
        tick(3);
        n_tests++;
        if (bus.dsp_gnt !== 1'b1) begin
            n_fail++; $display("FAIL handover_dsp_gnt: got %b expected 1", bus.dsp_gnt);
        end
        bus.cpu_req = 1'b1;
        bus.cpu_spi_cs_INV = 1'b0;
        bus.dsp_spi_cs_INV = 1'b0;
        tick(2);
        bus.dsp_req = 1'b0;
        tick(2);
        n_tests++;
        if (bus.dsp_gnt !== 1'b1) begin
            n_fail++; $display("FAIL handover_dsp_hold: got %b expected 1", bus.dsp_gnt);
        end
        tick(1);
        n_tests++;
        if ({bus.cpu_gnt, bus.dsp_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL handover_release: got %b%b expected 00", bus.cpu_gnt,
                               bus.dsp_gnt);
        end
        while (bus.cpu_gnt !== 1'b1 && n < 10) begin
            n_tests++;
            if (bus.flash_cs_INV !== 1'b1) begin
                n_fail++; $display("FAIL handover_guard_cs: got %b expected 1", bus.flash_cs_INV);
            end
            tick(1);
            n++;
        end
        // Four guard cycles plus the idle decision cycle.
        n_tests++;
        if (n != GUARD + 1) begin
            n_fail++; $display("FAIL handover_gap: got %0d expected %0d", n, GUARD + 1);
        end
        n_tests++;
        if (bus.flash_cs_INV !== 1'b0) begin
            n_fail++; $display("FAIL handover_cpu_cs: got %b expected 0", bus.flash_cs_INV);
        end
    endtask

    task automatic test_round_robin();
        int prev = 1;
        quiesce();
        bus.dsp_req = 1'b1;
        bus.cpu_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int who = -1;
            for (int k = 0; k < 14 && who < 0; k++) begin
                tick(1);
                if (bus.dsp_gnt === 1'b1 && bus.cpu_gnt === 1'b0) who = 0;
                else if (bus.cpu_gnt === 1'b1 && bus.dsp_gnt === 1'b0) who = 1;
            end
            n_tests++;
            if (who != 1 - prev) begin
                n_fail++; $display("FAIL round_robin_%0d: got owner %0d expected %0d", r, who,
                                   1 - prev);
            end
            prev = 1 - prev;
            tick(2);
            if (prev == 0) bus.dsp_req = 1'b0;
            else           bus.cpu_req = 1'b0;
            for (int k = 0; k < 6 && (bus.dsp_gnt === 1'b1 || bus.cpu_gnt === 1'b1); k++) tick(1);
            n_tests++;
            if ({bus.cpu_gnt, bus.dsp_gnt, bus.timeout_event} !== 3'b000) begin
                n_fail++; $display("FAIL round_robin_release_%0d: got %b%b%b expected 000", r,
                                   bus.cpu_gnt, bus.dsp_gnt, bus.timeout_event);
            end
            bus.dsp_req = 1'b1;
            bus.cpu_req = 1'b1;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        quiesce();
        bus.dsp_req = 1'b1;
        for (int k = 0; k < 8 && bus.dsp_gnt !== 1'b1; k++) tick(1);
        n_tests++;
        if (bus.dsp_gnt !== 1'b1) begin
            n_fail++; $display("FAIL timeout_gnt: got %b expected 1", bus.dsp_gnt);
        end
        while (bus.dsp_gnt === 1'b1 && n < 20) begin tick(1); n++; end
        n_tests++;
        if (n != TIMEOUT) begin
            n_fail++; $display("FAIL timeout_len: got %0d expected %0d", n, TIMEOUT);
        end
        n_tests++;
        if (bus.timeout_event !== 1'b1) begin
            n_fail++; $display("FAIL timeout_pulse: got %b expected 1", bus.timeout_event);
        end
        tick(1);
        n_tests++;
        if (bus.timeout_event !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse_end: got %b expected 0", bus.timeout_event);
        end
        for (int k = 0; k < 15; k++) begin
            n_tests++;
            if (bus.dsp_gnt !== 1'b0) begin
                n_fail++; $display("FAIL timeout_lockout: got %b expected 0", bus.dsp_gnt);
            end
            tick(1);
        end
        bus.dsp_req = 1'b0;
        tick(3);
        bus.dsp_req = 1'b1;
        n = 0;
        while (bus.dsp_gnt !== 1'b1 && n < 10) begin tick(1); n++; end
        n_tests++;
        if (bus.dsp_gnt !== 1'b1) begin
            n_fail++; $display("FAIL timeout_regrant: got %b expected 1", bus.dsp_gnt);
        end
    endtask

    task automatic test_async_reset();
        quiesce();
        bus.cpu_req = 1'b1;
        for (int k = 0; k < 8 && bus.cpu_gnt !== 1'b1; k++) tick(1);
        bus.cpu_spi_cs_INV = 1'b0;
        bus.cpu_spi_clk = 1'b1;
        #1;
        n_tests++;
        if ({bus.cpu_gnt, bus.flash_cs_INV} !== 2'b10) begin
            n_fail++; $display("FAIL async_pre: got %b%b expected 10", bus.cpu_gnt,
                               bus.flash_cs_INV);
        end
        #1 reset_INV = 1'b0;
        #1;
        n_tests++;
        if ({bus.cpu_gnt, bus.flash_cs_INV, bus.flash_clk} !== 3'b010) begin
            n_fail++; $display("FAIL async_reset: got %b%b%b expected 010", bus.cpu_gnt,
                               bus.flash_cs_INV, bus.flash_clk);
        end
        tick(2);
        reset_INV = 1'b1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_random();
        quiesce();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] exp_pins;
            logic [1:0] exp_miso;
            if ($urandom_range(7) == 0) bus.dsp_req = ~bus.dsp_req;
            if ($urandom_range(7) == 0) bus.cpu_req = ~bus.cpu_req;
            bus.cpu_spi_cs_INV = 1'($urandom);
            bus.cpu_spi_clk    = 1'($urandom);
            bus.cpu_spi_mosi   = 1'($urandom);
            bus.dsp_spi_cs_INV = 1'($urandom);
            bus.dsp_spi_clk    = 1'($urandom);
            bus.dsp_spi_mosi   = 1'($urandom);
            bus.flash_miso     = 1'($urandom);
            #1;
            exp_pins = 3'b100;
            exp_miso = 2'b00;
            if (m.owner == 0) begin
                exp_pins = {bus.dsp_spi_cs_INV, bus.dsp_spi_clk, bus.dsp_spi_mosi};
                exp_miso = {bus.flash_miso, 1'b0};
            end else if (m.owner == 1) begin
                exp_pins = {bus.cpu_spi_cs_INV, bus.cpu_spi_clk, bus.cpu_spi_mosi};
                exp_miso = {1'b0, bus.flash_miso};
            end
            n_tests++;
            if ({bus.dsp_gnt, bus.cpu_gnt, bus.timeout_event} !==
                {m.owner == 0, m.owner == 1, m.to}) begin
                n_fail++; $display("FAIL random_gnt_%0d: got %b%b%b expected %b%b%b", i,
                                   bus.dsp_gnt, bus.cpu_gnt, bus.timeout_event, m.owner == 0,
                                   m.owner == 1, m.to);
            end
            n_tests++;
            if ({bus.flash_cs_INV, bus.flash_clk, bus.flash_mosi} !== exp_pins ||
                {bus.dsp_spi_miso, bus.cpu_spi_miso} !== exp_miso) begin
                n_fail++; $display("FAIL random_mux_%0d: got %b%b%b/%b%b expected %b/%b", i,
                                   bus.flash_cs_INV, bus.flash_clk, bus.flash_mosi,
                                   bus.dsp_spi_miso, bus.cpu_spi_miso, exp_pins, exp_miso);
            end
            tick(1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_spi_cs_INV = 1'b1;
        bus.cpu_spi_clk    = 1'b0;
        bus.cpu_spi_mosi   = 1'b0;
        test_reset();
        test_single_owner();
        test_handover();
        test_round_robin();
        test_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
